// File: rtl/snvs_lp_zmk_xfer.sv
// snvs_lp_zmk_xfer: snapshots the ZMK and streams it as NWORDS key words over valid/ready.
// Define SNVS_ZMK_XFER_PARITY_EN to drive even parity of each key word on key_par.
module snvs_lp_zmk_xfer #(
    parameter int SNVS_ZMK_WIDTH  = 256,
    parameter int SNVS_DATA_WIDTH = 32
) (
    input  logic                       ipg_clk,
    input  logic                       ipg_hard_async_reset_b,
    input  logic [SNVS_ZMK_WIDTH-1:0]  lpzmk_reg,
    input  logic                       zmk_valid,
    input  logic                       zmk_soft_reset,
    input  logic                       xfer_req,
    output logic [SNVS_DATA_WIDTH-1:0] key_data,
    output logic                       key_valid,
    input  logic                       key_ready,
    output logic                       key_last,
    output logic                       key_par,
    output logic                       xfer_busy,
    output logic                       xfer_done,
    output logic                       xfer_err
);
    localparam int NWORDS = SNVS_ZMK_WIDTH / SNVS_DATA_WIDTH;
    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;

    state_e                    state_q, state_d;
    logic [SNVS_ZMK_WIDTH-1:0] shadow_q, shadow_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic                      err_q, err_d;

    always_ff @(posedge ipg_clk or negedge ipg_hard_async_reset_b) begin
        if (!ipg_hard_async_reset_b) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
        end
    end

    // Zeroization outranks a concurrent final beat, so an aborted key never reports done.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer_req && zmk_valid && !zmk_soft_reset) begin
                    state_d  = XFER;
                    shadow_d = lpzmk_reg;
                    idx_d    = '0;
                end else if (xfer_req) begin
                    err_d = 1'b1;
                end
            end
            XFER: begin
                if (zmk_soft_reset) begin
                    state_d  = IDLE;
                    shadow_d = '0;
                    idx_d    = '0;
                    err_d    = 1'b1;
                end else if (key_ready) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = (idx_q == LAST) ? DONE : XFER;
                end
            end
            default: begin
                state_d  = IDLE;
                shadow_d = '0;
                idx_d    = '0;
            end
        endcase
    end

    always_comb begin
        key_valid = (state_q == XFER);
        key_data  = key_valid ? shadow_q[int'(idx_q) * SNVS_DATA_WIDTH +: SNVS_DATA_WIDTH] : '0;
        key_last  = key_valid && (idx_q == LAST);
        xfer_busy = key_valid;
        xfer_done = (state_q == DONE);
        xfer_err  = err_q;
`ifdef SNVS_ZMK_XFER_PARITY_EN
        key_par   = ^key_data;
`else
        key_par   = 1'b0;
`endif
    end
endmodule

// File: tb/tb_snvs_lp_zmk_xfer.sv
// tb_snvs_lp_zmk_xfer: randomized scenarios checked against a word-queue model of the key stream.
module tb_snvs_lp_zmk_xfer;
`ifdef SNVS_ZMK_XFER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    logic         ipg_clk = 1'b0;
    logic         rst_b;
    logic [255:0] lpzmk_reg;
    logic         zmk_valid, zmk_soft_reset, xfer_req, key_ready;
    logic [31:0]  key_data;
    logic         key_valid, key_last, key_par, xfer_busy, xfer_done, xfer_err;
    int           checks = 0;
    int           failures = 0;

    always #5 ipg_clk = ~ipg_clk;

    snvs_lp_zmk_xfer dut (
        .ipg_clk(ipg_clk), .ipg_hard_async_reset_b(rst_b), .lpzmk_reg(lpzmk_reg),
        .zmk_valid(zmk_valid), .zmk_soft_reset(zmk_soft_reset), .xfer_req(xfer_req),
        .key_data(key_data), .key_valid(key_valid), .key_ready(key_ready),
        .key_last(key_last), .key_par(key_par), .xfer_busy(xfer_busy),
        .xfer_done(xfer_done), .xfer_err(xfer_err)
    );

    task automatic step();
        @(posedge ipg_clk);
        #1;
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom();
        return k;
    endfunction

    // mode: 0 ready always, 1 ready every other cycle, 2 random ready/zmk_valid/xfer_req
    task automatic run_xfer(input logic [255:0] key, input int mode, input int abort_beat,
                            input int ovr_beat, input bit req_in_done, input bit started);
        logic [31:0] q[$];
        int          beats = 0;
        int          cyc = 0;
        bit          abort = 1'b0;
        bit          rdy;
        logic [5:0]  ef;
        for (int i = 0; i < 8; i++) q.push_back(key[32*i +: 32]);
        if (!started) begin
            lpzmk_reg = key;
            zmk_valid = 1'b1;
            xfer_req  = 1'b1;
            step();
            xfer_req  = 1'b0;
        end
        while (q.size() > 0 && cyc < 64) begin
            ef = {1'b1, q.size() == 1, 1'b1, 2'b00, PAR ? ^q[0] : 1'b0};
            checks++;
            if ({key_valid, key_last, xfer_busy, xfer_done, xfer_err, key_par} !== ef) begin
                failures++;
                $display("FAIL beat_flags beat=%0d got=%b exp=%b", beats,
                         {key_valid, key_last, xfer_busy, xfer_done, xfer_err, key_par}, ef);
            end
            checks++;
            if (key_data !== q[0]) begin
                failures++;
                $display("FAIL beat_data beat=%0d got=%h exp=%h", beats, key_data, q[0]);
            end
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 1) : ($urandom_range(1) == 1);
            key_ready = rdy;
            zmk_soft_reset = (beats == abort_beat);
            abort = zmk_soft_reset;
            if (ovr_beat >= 0 && beats >= ovr_beat) lpzmk_reg = '1;
            if (mode == 2) begin
                zmk_valid = ($urandom_range(1) == 1);
                xfer_req  = (q.size() > 1) && ($urandom_range(1) == 1);
            end
            step();
            cyc++;
            key_ready = 1'b0;
            zmk_soft_reset = 1'b0;
            xfer_req = 1'b0;
            zmk_valid = 1'b1;
            if (abort) begin
                checks++;
                if ({key_valid, xfer_busy, xfer_done, xfer_err, key_data} !== {4'b0001, 32'h0}) begin
                    failures++;
                    $display("FAIL abort got v=%b b=%b d=%b e=%b data=%h exp v=0 b=0 d=0 e=1 data=0",
                             key_valid, xfer_busy, xfer_done, xfer_err, key_data);
                end
                step();
                checks++;
                if ({key_valid, xfer_done, xfer_err} !== 3'b000) begin
                    failures++;
                    $display("FAIL abort_after got=%b exp=000", {key_valid, xfer_done, xfer_err});
                end
                return;
            end
            if (rdy) begin
                void'(q.pop_front());
                beats++;
            end
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL xfer_timeout words_left=%0d exp=0", q.size());
        end
        if (mode < 2) begin
            checks++;
            if (cyc != (mode == 0 ? 8 : 16)) begin
                failures++;
                $display("FAIL xfer_cycles got=%0d exp=%0d", cyc, mode == 0 ? 8 : 16);
            end
        end
        checks++;
        if ({key_valid, xfer_done, xfer_err, key_data} !== {3'b010, 32'h0}) begin
            failures++;
            $display("FAIL done got v=%b d=%b e=%b data=%h exp v=0 d=1 e=0 data=0",
                     key_valid, xfer_done, xfer_err, key_data);
        end
        xfer_req = req_in_done;
        step();
        checks++;
        if ({key_valid, xfer_done, xfer_err} !== 3'b000) begin
            failures++;
            $display("FAIL post_done got=%b exp=000", {key_valid, xfer_done, xfer_err});
        end
        if (req_in_done) begin
            step();
            xfer_req = 1'b0;
            checks++;
            if (key_valid !== 1'b1) begin
                failures++;
                $display("FAIL restart key_valid got=%b exp=1", key_valid);
            end
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        lpzmk_reg = '0;
        zmk_valid = 1'b0;
        zmk_soft_reset = 1'b0;
        xfer_req = 1'b0;
        key_ready = 1'b0;
        repeat (2) step();
        checks++;
        if ({key_data, key_valid, key_last, key_par, xfer_busy, xfer_done, xfer_err} !== 38'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {key_data, key_valid, key_last, key_par, xfer_busy, xfer_done, xfer_err});
        end
        rst_b = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = {4{8'(i)}};
        run_xfer(k, 0, -1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        run_xfer(rand_key(), 1, -1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_snapshot();
        run_xfer(rand_key(), 0, -1, 2, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        run_xfer(rand_key(), 0, 4, -1, 1'b0, 1'b0);
    endtask

    task automatic test_refused();
        for (int v = 0; v < 2; v++) begin
            zmk_valid = (v == 1);
            zmk_soft_reset = (v == 1);
            xfer_req = 1'b1;
            lpzmk_reg = rand_key();
            step();
            xfer_req = 1'b0;
            zmk_soft_reset = 1'b0;
            checks++;
            if ({key_valid, xfer_busy, xfer_err} !== 3'b001) begin
                failures++;
                $display("FAIL refused_err case=%0d got=%b exp=001", v, {key_valid, xfer_busy, xfer_err});
            end
            for (int c = 0; c < 3; c++) begin
                step();
                checks++;
                if ({key_valid, xfer_err, key_data} !== 34'h0) begin
                    failures++;
                    $display("FAIL refused_idle case=%0d got v=%b e=%b data=%h exp 0",
                             v, key_valid, xfer_err, key_data);
                end
            end
        end
        zmk_valid = 1'b1;
    endtask

    task automatic test_abort_last();
        logic [255:0] k;
        k = rand_key();
        k[255:224] = 32'h0000_0007;
        run_xfer(k, 0, 7, -1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++)
            run_xfer(rand_key(), 2, int'($urandom_range(0, 15)), -1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_xfer(rand_key(), 0, -1, -1, 1'b1, 1'b0);
        run_xfer(lpzmk_reg, 0, -1, -1, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        lpzmk_reg = rand_key();
        zmk_valid = 1'b1;
        xfer_req = 1'b1;
        step();
        xfer_req = 1'b0;
        key_ready = 1'b1;
        repeat (3) step();
        key_ready = 1'b0;
        #2 rst_b = 1'b0;
        #1;
        checks++;
        if ({key_data, key_valid, key_last, xfer_busy, xfer_done, xfer_err} !== 37'h0) begin
            failures++;
            $display("FAIL async_reset got v=%b b=%b data=%h exp 0", key_valid, xfer_busy, key_data);
        end
        step();
        #2 rst_b = 1'b1;
        step();
        checks++;
        if ({key_valid, key_data} !== 33'h0) begin
            failures++;
            $display("FAIL async_release got v=%b data=%h exp 0", key_valid, key_data);
        end
        run_xfer(rand_key(), 0, -1, -1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_snapshot();
        test_abort();
        test_refused();
        test_abort_last();
        test_random();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
